// File: rtl/cmac_bringup_sequencer.sv
// Init-clock reset/bring-up sequencer for one CMAC port: QPLL0 -> GT -> core resets,
// then RX alignment, with lock/align timeouts, bounded retries and a sticky FAIL state.
module cmac_bringup_sequencer #(
  parameter int unsigned N_COMMON             = 2,
  parameter int unsigned QPLL_RESET_CYCLES    = 128,
  parameter int unsigned GT_RESET_CYCLES      = 256,
  parameter int unsigned CORE_RESET_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 1048576,
  parameter int unsigned ALIGN_TIMEOUT_CYCLES = 4194304,
  parameter int unsigned MAX_RETRIES          = 3
) (
  input  logic                init_clk,
  input  logic                init_rst_n,
  input  logic                gt_powergood,
  input  logic [N_COMMON-1:0] qpll0lock,
  input  logic                rx_aligned,
  input  logic                restart,
  output logic [N_COMMON-1:0] qpll0reset,
  output logic                gt_tx_reset,
  output logic                gt_rx_reset,
  output logic                core_drp_reset,
  output logic                core_tx_reset,
  output logic                core_rx_reset,
  output logic                bringup_done,
  output logic                bringup_error,
  output logic [1:0]          retry_count,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    QPLL_RST   = 3'd1,
    QPLL_WAIT  = 3'd2,
    GT_RST     = 3'd3,
    CORE_RST   = 3'd4,
    ALIGN_WAIT = 3'd5,
    RUN        = 3'd6,
    FAIL       = 3'd7
  } state_e;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAXP = max2(max2(max2(QPLL_RESET_CYCLES, GT_RESET_CYCLES),
                                           max2(CORE_RESET_CYCLES, LOCK_TIMEOUT_CYCLES)),
                                      ALIGN_TIMEOUT_CYCLES);
  localparam int unsigned CW   = (MAXP > 2) ? $clog2(MAXP) : 1;
  localparam int unsigned SW   = N_COMMON + 2;

  logic [SW-1:0]       sync1_q, sync2_q;
  logic                powergood_s, rx_aligned_s;
  logic [N_COMMON-1:0] qpll0lock_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d, retry_inc;
  logic          timeout;

  logic qrst_q, qrst_d, gtrst_q, gtrst_d, drp_q, drp_d;
  logic corerst_q, corerst_d, done_q, done_d, err_q, err_d;

  assign powergood_s  = sync2_q[SW-1];
  assign rx_aligned_s = sync2_q[SW-2];
  assign qpll0lock_s  = sync2_q[N_COMMON-1:0];

  // Dwell counts are loaded as N-1 so a state lasts exactly N cycles (N=1 -> one cycle).
  function automatic logic [CW-1:0] load_val(state_e s);
    case (s)
      QPLL_RST:   return CW'(QPLL_RESET_CYCLES - 1);
      QPLL_WAIT:  return CW'(LOCK_TIMEOUT_CYCLES - 1);
      GT_RST:     return CW'(GT_RESET_CYCLES - 1);
      CORE_RST:   return CW'(CORE_RESET_CYCLES - 1);
      ALIGN_WAIT: return CW'(ALIGN_TIMEOUT_CYCLES - 1);
      default:    return '0;
    endcase
  endfunction

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      qrst_q    <= 1'b1;
      gtrst_q   <= 1'b1;
      drp_q     <= 1'b1;
      corerst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= {gt_powergood, rx_aligned, qpll0lock};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      qrst_q    <= qrst_d;
      gtrst_q   <= gtrst_d;
      drp_q     <= drp_d;
      corerst_q <= corerst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    timeout   = 1'b0;
    retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    if (!powergood_s && state_q != IDLE) begin
      state_d = IDLE;
    end else if (restart) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE:       if (powergood_s) state_d = QPLL_RST;
        QPLL_RST:   if (cnt_q == '0) state_d = QPLL_WAIT;
        QPLL_WAIT: begin
          // Lock on the expiry cycle wins over the timeout.
          if (&qpll0lock_s)      state_d = GT_RST;
          else if (cnt_q == '0)  timeout = 1'b1;
        end
        GT_RST:     if (cnt_q == '0) state_d = CORE_RST;
        CORE_RST:   if (cnt_q == '0) state_d = ALIGN_WAIT;
        ALIGN_WAIT: begin
          if (rx_aligned_s) begin
            state_d = RUN;
            retry_d = '0;
          end else if (cnt_q == '0) begin
            timeout = 1'b1;
          end
        end
        RUN: begin
          if (!(&qpll0lock_s))   state_d = QPLL_RST;
          else if (!rx_aligned_s) state_d = CORE_RST;
        end
        default: ;
      endcase
      if (timeout) begin
        retry_d = retry_inc;
        state_d = (32'(retry_inc) >= MAX_RETRIES) ? FAIL : QPLL_RST;
      end
    end

    if (state_d != state_q)  cnt_d = load_val(state_d);
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
    else                     cnt_d = cnt_q;

    // Outputs are decoded from the next state so they register alongside state_q.
    qrst_d    = (state_d == IDLE) || (state_d == QPLL_RST) || (state_d == FAIL);
    drp_d     = (state_d <= QPLL_WAIT) || (state_d == FAIL);
    gtrst_d   = (state_d <= GT_RST) || (state_d == FAIL);
    corerst_d = (state_d <= CORE_RST) || (state_d == FAIL);
    done_d    = (state_d == RUN);
    err_d     = (state_d == FAIL);
  end

  assign qpll0reset     = {N_COMMON{qrst_q}};
  assign gt_tx_reset    = gtrst_q;
  assign gt_rx_reset    = gtrst_q;
  assign core_drp_reset = drp_q;
  assign core_tx_reset  = corerst_q;
  assign core_rx_reset  = corerst_q;
  assign bringup_done   = done_q;
  assign bringup_error  = err_q;
  assign retry_count    = retry_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_cmac_bringup_sequencer.sv
// Scoreboarded bench for cmac_bringup_sequencer: expected state sequence queued by the
// stimulus, checked with per-state output levels by a monitor on every state change.
module tb_cmac_bringup_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pg = 1'b0;
  logic [1:0] lock = 2'b00;
  logic       aligned = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] qpll0reset;
  logic       gt_tx_reset, gt_rx_reset, core_drp_reset, core_tx_reset, core_rx_reset;
  logic       bringup_done, bringup_error;
  logic [1:0] retry_count;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Short timeouts keep the retry scenario well inside the cycle budget.
  cmac_bringup_sequencer #(
    .N_COMMON(2),
    .QPLL_RESET_CYCLES(128),
    .GT_RESET_CYCLES(256),
    .CORE_RESET_CYCLES(64),
    .LOCK_TIMEOUT_CYCLES(1000),
    .ALIGN_TIMEOUT_CYCLES(2000),
    .MAX_RETRIES(3)
  ) dut (
    .init_clk(clk), .init_rst_n(rst_n), .gt_powergood(pg), .qpll0lock(lock),
    .rx_aligned(aligned), .restart(restart), .qpll0reset(qpll0reset),
    .gt_tx_reset(gt_tx_reset), .gt_rx_reset(gt_rx_reset),
    .core_drp_reset(core_drp_reset), .core_tx_reset(core_tx_reset),
    .core_rx_reset(core_rx_reset), .bringup_done(bringup_done),
    .bringup_error(bringup_error), .retry_count(retry_count), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // {qpll0reset[1:0], gt_tx, gt_rx, drp, core_tx, core_rx, done, error}
  function automatic logic [8:0] exp_outs(input int s);
    logic q, d, g, c;
    q = (s == 0) || (s == 1) || (s == 7);
    d = (s <= 2) || (s == 7);
    g = (s <= 3) || (s == 7);
    c = (s <= 4) || (s == 7);
    return {q, q, g, g, d, c, c, (s == 6), (s == 7)};
  endfunction

  function automatic logic [8:0] act_outs();
    return {qpll0reset, gt_tx_reset, gt_rx_reset, core_drp_reset,
            core_tx_reset, core_rx_reset, bringup_done, bringup_error};
  endfunction

  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (state_out !== prev_state) begin
      if (exp_q.size() == 0) chk("seq_unexpected", 32'(state_out), 32'hFF);
      else                   chk("seq_state", 32'(state_out), 32'(exp_q.pop_front()));
      chk("state_outs", 32'(act_outs()), 32'(exp_outs(int'(state_out))));
      prev_state = state_out;
    end
  end

  task automatic wait_state(input string tag, input int s, input int limit);
    int n = 0;
    while (int'(state_out) != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_out), 32'(s));
  endtask

  initial begin
    int cnt, n;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_outs", 32'(act_outs()), 32'(9'b111111100));
    chk("rst_retry", 32'(retry_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full bring-up
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
    pg = 1'b1;
    wait_state("reach_qpll_rst", 1, 10);
    cnt = 0; n = 0;
    while (state_out == 3'd1 && n < 1000) begin
      if (qpll0reset == 2'b11) cnt++;
      @(negedge clk);
      n++;
    end
    chk("qpll_rst_len", 32'(cnt), 128);
    chk("qpll_rst_low_in_wait", 32'(qpll0reset), 0);
    repeat (10) @(negedge clk);
    lock = 2'b11;
    wait_state("reach_align_wait", 5, 500);
    repeat (50) @(negedge clk);
    aligned = 1'b1;
    wait_state("reach_run", 6, 10);
    chk("run_done", 32'(bringup_done), 1);
    chk("run_retry", 32'(retry_count), 0);

    // Lock loss on one common
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
    lock[1] = 1'b0;
    wait_state("lockloss_qpll_rst", 1, 5);
    chk("lockloss_done", 32'(bringup_done), 0);
    repeat (20) @(negedge clk);
    lock[1] = 1'b1;
    wait_state("lockloss_rerun", 6, 1000);
    chk("lockloss_retry", 32'(retry_count), 0);

    // Align loss only
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
    aligned = 1'b0;
    wait_state("alignloss_core_rst", 4, 5);
    cnt = 0; n = 0;
    while (state_out == 3'd4 && n < 200) begin
      if (core_tx_reset && core_rx_reset) cnt++;
      if (gt_tx_reset || gt_rx_reset || qpll0reset != 2'b00) cnt += 1000;
      @(negedge clk);
      n++;
    end
    chk("core_rst_len", 32'(cnt), 64);
    aligned = 1'b1;
    wait_state("alignloss_rerun", 6, 20);

    // Permanent partial lock -> three timeouts -> FAIL
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(7);
    lock = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      wait_state("to_wait", 2, 300);
      n = 0;
      while (state_out == 3'd2 && n < 1100) begin
        @(negedge clk);
        n++;
      end
      chk("to_retry", 32'(retry_count), 32'(k));
    end
    chk("fail_state", 32'(state_out), 7);
    chk("fail_outs", 32'(act_outs()), 32'(9'b111111101));
    repeat (20) @(negedge clk);
    chk("fail_sticky", 32'(state_out), 7);

    // Restart out of FAIL, then power-good loss in GT_RST
    lock = 2'b11;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_idle", 32'(state_out), 0);
    chk("restart_retry", 32'(retry_count), 0);
    wait_state("reach_gt_rst", 3, 300);
    repeat (30) @(negedge clk);
    exp_q.push_back(0);
    pg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pgloss_idle", 32'(state_out), 0);
    chk("pgloss_outs", 32'(act_outs()), 32'(9'b111111100));

    // Async reset during ALIGN_WAIT
    aligned = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5);
    pg = 1'b1;
    wait_state("reach_align_wait2", 5, 800);
    repeat (10) @(negedge clk);
    exp_q.push_back(0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_out), 0);
    chk("async_rst_outs", 32'(act_outs()), 32'(9'b111111100));
    chk("async_rst_retry", 32'(retry_count), 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
